// File: rtl/control_pipeline.sv
// control_pipeline: carries the decode control bundle through EX/MEM/WB and
// unpacks each field in the stage that consumes it. Owns bubble insertion on
// stall/flush, whole-pipe freeze on mem_wait_i, and load-use hazard detection.
// Optional feature macro: CTRL_PIPE_RESERVED_CHECK_EN (reserved-bit trap).
module control_pipeline #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [19:0]           id_ctrl_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  mem_wait_i,
    output logic [3:0]            ex_alu_op_o,
    output logic [3:0]            ex_alu_vec_op_o,
    output logic                  mem_load_o,
    output logic                  mem_we_a_o,
    output logic                  mem_we_b_o,
    output logic                  wb_wre_o,
    output logic                  wb_vwre_o,
    output logic [1:0]            wb_sel_o,
    output logic [1:0]            wb_vsel_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic                  load_use_hazard_o,
    output logic                  illegal_o
);

    // Bit positions inside the 17-bit stored bundle
    localparam int B_LOAD  = 16;
    localparam int B_WRE   = 15;
    localparam int B_VWRE  = 14;
    localparam int B_WE_A  = 13;
    localparam int B_WE_B  = 12;

    typedef struct packed {
        logic                  valid;
        logic [16:0]           ctrl;
        logic [REG_ADDR_W-1:0] rd;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;
    stage_t ex_d, mem_d, wb_d;
    stage_t id_entry;
    logic   ill_set;

    assign id_entry = '{valid: id_valid_i, ctrl: id_ctrl_i[16:0], rd: id_rd_i};

`ifdef CTRL_PIPE_RESERVED_CHECK_EN
    logic illegal_q;
    assign illegal_o = illegal_q;
`else
    // Reserved bits carry no meaning when the trap is compiled out
    logic unused_rsvd;
    assign unused_rsvd = ^id_ctrl_i[19:17];
    assign illegal_o   = 1'b0;
`endif

    // Next-state selection: mem_wait freezes, flush beats stall, else advance
    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        ill_set = 1'b0;
        if (mem_wait_i) begin
            ex_d  = ex_q;
            mem_d = mem_q;
            wb_d  = wb_q;
        end else if (flush_i) begin
            ex_d  = '0;
            mem_d = '0;
            wb_d  = mem_q;
        end else if (stall_i) begin
            ex_d  = '0;
            mem_d = ex_q;
            wb_d  = mem_q;
        end else begin
            ex_d  = id_entry;
            mem_d = ex_q;
            wb_d  = mem_q;
`ifdef CTRL_PIPE_RESERVED_CHECK_EN
            // Reserved encodings are trapped only when EX would actually take them
            if (id_valid_i && (id_ctrl_i[19:17] != 3'b000)) begin
                ex_d    = '0;
                ill_set = 1'b1;
            end
`endif
        end
    end

    // Stage registers with synchronous active-low reset to bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

`ifdef CTRL_PIPE_RESERVED_CHECK_EN
    // Sticky reserved-bit error, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n)       illegal_q <= 1'b0;
        else if (ill_set) illegal_q <= 1'b1;
    end
`else
    logic unused_ill;
    assign unused_ill = ill_set;
`endif

    // EX consumes ALU ops raw; bubbles carry zero ctrl so they read 0
    assign ex_alu_op_o     = ex_q.ctrl[7:4];
    assign ex_alu_vec_op_o = ex_q.ctrl[3:0];

    // MEM enables qualified by stage valid
    assign mem_load_o = mem_q.valid & mem_q.ctrl[B_LOAD];
    assign mem_we_a_o = mem_q.valid & mem_q.ctrl[B_WE_A];
    assign mem_we_b_o = mem_q.valid & mem_q.ctrl[B_WE_B];

    // WB enables qualified; selects and rd raw
    assign wb_wre_o  = wb_q.valid & wb_q.ctrl[B_WRE];
    assign wb_vwre_o = wb_q.valid & wb_q.ctrl[B_VWRE];
    assign wb_sel_o  = wb_q.ctrl[11:10];
    assign wb_vsel_o = wb_q.ctrl[9:8];
    assign wb_rd_o   = wb_q.rd;

    // Fields WB carries along but nobody downstream reads
    logic unused_wb;
    assign unused_wb = ^{wb_q.ctrl[16], wb_q.ctrl[13:12], wb_q.ctrl[7:0]};

    // Load in EX writing a register that decode is about to read
    assign load_use_hazard_o = ex_q.valid & ex_q.ctrl[B_LOAD]
                             & (ex_q.ctrl[B_WRE] | ex_q.ctrl[B_VWRE])
                             & id_valid_i
                             & ((ex_q.rd == id_rs1_i) | (ex_q.rd == id_rs2_i));

endmodule

// File: tb/tb_control_pipeline.sv
// Directed, table-driven bench for control_pipeline.
module tb_control_pipeline;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] id_ctrl_i;
    logic        id_valid_i;
    logic [3:0]  id_rd_i, id_rs1_i, id_rs2_i;
    logic        stall_i, flush_i, mem_wait_i;
    logic [3:0]  ex_alu_op_o, ex_alu_vec_op_o;
    logic        mem_load_o, mem_we_a_o, mem_we_b_o;
    logic        wb_wre_o, wb_vwre_o;
    logic [1:0]  wb_sel_o, wb_vsel_o;
    logic [3:0]  wb_rd_o;
    logic        load_use_hazard_o, illegal_o;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    control_pipeline #(.REG_ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_ctrl_i(id_ctrl_i), .id_valid_i(id_valid_i),
        .id_rd_i(id_rd_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .stall_i(stall_i), .flush_i(flush_i), .mem_wait_i(mem_wait_i),
        .ex_alu_op_o(ex_alu_op_o), .ex_alu_vec_op_o(ex_alu_vec_op_o),
        .mem_load_o(mem_load_o), .mem_we_a_o(mem_we_a_o), .mem_we_b_o(mem_we_b_o),
        .wb_wre_o(wb_wre_o), .wb_vwre_o(wb_vwre_o),
        .wb_sel_o(wb_sel_o), .wb_vsel_o(wb_vsel_o), .wb_rd_o(wb_rd_o),
        .load_use_hazard_o(load_use_hazard_o), .illegal_o(illegal_o)
    );

`ifdef CTRL_PIPE_RESERVED_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    localparam logic [19:0] A  = 20'h0A53C;
    localparam logic [19:0] LD = 20'h18000;
    localparam logic [19:0] B  = 20'h08070;
    localparam logic [19:0] S1 = 20'h08000;
    localparam logic [19:0] ST = 20'h02000;
    localparam logic [19:0] I1 = 20'h09012;
    localparam logic [19:0] I2 = 20'h04034;
    localparam logic [19:0] I3 = 20'h00056;
    localparam logic [19:0] J  = 20'h0E000;
    localparam logic [19:0] R  = 20'h90000;
    localparam logic [21:0] Z  = 22'd0;

    typedef struct {
        logic        rst, vld, st, fl, mw, haz;
        logic [19:0] ctrl;
        logic [3:0]  rd, rs1, rs2;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];

    logic [21:0] got;
    assign got = {ex_alu_op_o, ex_alu_vec_op_o, mem_load_o, mem_we_a_o, mem_we_b_o,
                  wb_wre_o, wb_vwre_o, wb_sel_o, wb_vsel_o, wb_rd_o, illegal_o};

    // Expected registered outputs, same packing as got
    function automatic logic [21:0] e(input logic [3:0] alu, input logic [3:0] vec,
                                      input logic ld, input logic wa, input logic wb,
                                      input logic wre, input logic vwre,
                                      input logic [1:0] sel, input logic [1:0] vsel,
                                      input logic [3:0] rd, input logic ill);
        return {alu, vec, ld, wa, wb, wre, vwre, sel, vsel, rd, ill};
    endfunction

    task automatic add(input logic rst, input logic vld, input logic [19:0] ctrl,
                       input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic st, input logic fl, input logic mw,
                       input logic haz, input logic [21:0] exp);
        vec_t v;
        v.rst = rst; v.vld = vld; v.ctrl = ctrl; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.st = st; v.fl = fl; v.mw = mw; v.haz = haz; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic [21:0] exp);
        add(1, 0, 20'h0, 0, 0, 0, 0, 0, 0, 0, exp);
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst; id_valid_i = v.vld; id_ctrl_i = v.ctrl; id_rd_i = v.rd;
        id_rs1_i = v.rs1; id_rs2_i = v.rs2; stall_i = v.st; flush_i = v.fl;
        mem_wait_i = v.mw;
    endtask

    task automatic chk_out(input string name, input logic [21:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s outputs got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic chk_haz(input string name, input logic exp);
        n_run++;
        if (load_use_hazard_o !== exp) begin
            n_fail++;
            $display("FAIL %s hazard got=%b want=%b", name, load_use_hazard_o, exp);
        end
    endtask

    initial begin
        vec_t v;
        // Reset + single bundle through all stages
        add(0, 0, 20'h0, 0, 0, 0, 0, 0, 0, 0, Z);
        add(1, 1, A, 3, 0, 0, 0, 0, 0, 0, e(3, 4'hC, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        idle(e(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        idle(e(0, 0, 0, 0, 0, 1, 0, 1, 1, 3, 0));
        idle(Z);
        // Load-use: hazard, one stall, load reaches WB
        add(1, 1, LD, 5, 0, 0, 0, 0, 0, 0, Z);
        add(1, 1, B, 6, 5, 0, 1, 0, 0, 1, e(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add(1, 1, B, 6, 5, 0, 0, 0, 0, 0, e(7, 0, 0, 0, 0, 1, 0, 0, 0, 5, 0));
        idle(Z);
        idle(e(0, 0, 0, 0, 0, 1, 0, 0, 0, 6, 0));
        idle(Z);
        // Flush (with stall also high) squashes store in EX; older MEM reaches WB
        add(1, 1, S1, 2, 0, 0, 0, 0, 0, 0, Z);
        add(1, 1, ST, 0, 0, 0, 0, 0, 0, 0, Z);
        add(1, 0, 20'h0, 0, 0, 0, 1, 1, 0, 0, e(0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0));
        idle(Z);
        // mem_wait 3 cycles with stall held: freeze, then resume without bubble
        add(1, 1, I1, 1, 0, 0, 0, 0, 0, 0, e(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(1, 1, I2, 2, 0, 0, 0, 0, 0, 0, e(3, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            add(1, 1, I3, 3, 0, 0, 1, 0, 1, 0, e(3, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add(1, 1, I3, 3, 0, 0, 0, 0, 0, 0, e(5, 6, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        idle(e(0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0));
        idle(e(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        // Reset mid-stream with three in flight
        add(1, 1, J, 7, 0, 0, 0, 0, 0, 0, Z);
        add(1, 1, J, 8, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add(1, 1, J, 9, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 1, 1, 0, 0, 7, 0));
        add(0, 1, J, 9, 0, 0, 0, 0, 0, 0, Z);
        idle(Z);
        idle(Z);
        // Reserved bits
        add(1, 1, R, 4, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RC));
        idle(e(0, 0, !RC, 0, 0, 0, 0, 0, 0, 0, RC));
        idle(e(0, 0, 0, 0, 0, 0, 0, 0, 0, RC ? 4'd0 : 4'd4, RC));
        add(0, 0, 20'h0, 0, 0, 0, 0, 0, 0, 0, Z);
        // Hazard qualifiers: id_valid low, rs2 match
        add(1, 1, LD, 5, 0, 0, 0, 0, 0, 0, Z);
        add(1, 0, 20'h0, 0, 0, 5, 0, 0, 0, 0, e(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add(1, 1, LD, 5, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 0));
        add(1, 1, 20'h0, 0, 0, 5, 0, 0, 0, 1, e(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        // Initial reset
        v = tbl[0];
        drive(v);
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            chk_haz($sformatf("vec%0d", i), tbl[i].haz);
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Back-to-back stall: EX keeps taking bubbles while older work drains
        v = tbl[0];
        v.rst = 1; v.vld = 1; v.ctrl = B; v.rd = 6;
        drive(v);
        @(posedge clk); #1;
        chk_out("seq_b_in", e(7, 0, 0, 0, 0, 1, 0, 0, 0, 5, 0));
        v.ctrl = A; v.rd = 3; v.st = 1;
        drive(v);
        @(posedge clk); #1;
        chk_out("seq_stall1", Z);
        @(posedge clk); #1;
        chk_out("seq_stall2", e(0, 0, 0, 0, 0, 1, 0, 0, 0, 6, 0));
        v.st = 0;
        drive(v);
        @(posedge clk); #1;
        chk_out("seq_release", e(3, 4'hC, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
